// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Defaults, the read-return tag and the round-robin pick.
package mem_port_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_RD_LAT = 1;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  // First active request at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] g;
    logic [IDX_W-1:0]   j;
    g = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = IDX_W'((32'(ptr) + i) % n);
      if (i < n && g == '0 && req[j])
        g[j] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Pointer moves just past the last winner.
module rr_arbiter
  import mem_port_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [MAX_REQ-1:0] pick;

  assign pick = rr_pick(MAX_REQ'(req), IDX_W'(ptr), N);
  assign gnt  = N'(pick);

  always_comb begin
    idx     = '0;
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        idx     = IDX_W'(i);
        ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin arbiter in front of one block-RAM port.
// Read data is steered back to its issuer by a tag pipeline.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*BE_W-1:0]    req_we,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BE_W-1:0]          mem_we,
  output logic [DATA_W-1:0]        mem_data_i,
  input  logic [DATA_W-1:0]        mem_data_o
);

  logic [IDX_W-1:0]  gidx;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wd;
  rd_tag_t           tag_in;
  rd_tag_t [RD_LAT:0] pipe;
  logic [N_REQ-1:0]  rv_nxt;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .idx   (gidx)
  );

  assign accept = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_we   = '0;
    sel_wd   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_we   = req_we[i*BE_W +: BE_W];
        sel_wd   = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_data_i <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept ? sel_we : '0;
      if (accept) begin
        mem_addr   <= sel_addr;
        mem_data_i <= sel_wd;
      end
    end
  end

  // Tag reaches the last stage in the cycle mem_data_o is valid.
  assign tag_in.valid = accept && (sel_we == '0);
  assign tag_in.idx   = gidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pipe <= '0;
    else
      pipe <= {pipe[RD_LAT-1:0], tag_in};
  end

  always_comb begin
    rv_nxt = '0;
    for (int i = 0; i < N_REQ; i++)
      rv_nxt[i] = pipe[RD_LAT].valid &&
                  (pipe[RD_LAT].idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= rv_nxt;
      if (pipe[RD_LAT].valid)
        rdata <= mem_data_o;
    end
  end

endmodule
